// File: rtl/mbc3_pkg.sv
// Shared constants for the MBC3 cartridge mapper: address regions, RTC
// register select codes and RTC field widths.
package mbc3_pkg;

  localparam int ROM_BANK_W = 7;
  localparam int SEC_W      = 6;
  localparam int MIN_W      = 6;
  localparam int HR_W       = 5;
  localparam int DAY_W      = 9;

  // Regions decoded from a[15:13]
  localparam logic [2:0] RGN_RAM_EN   = 3'd0;  // 0000-1FFF
  localparam logic [2:0] RGN_ROM_BANK = 3'd1;  // 2000-3FFF
  localparam logic [2:0] RGN_SEL      = 3'd2;  // 4000-5FFF
  localparam logic [2:0] RGN_LATCH    = 3'd3;  // 6000-7FFF
  localparam logic [2:0] RGN_EXT_RAM  = 3'd5;  // A000-BFFF

  typedef enum logic [3:0] {
    RTC_S  = 4'h8,
    RTC_M  = 4'h9,
    RTC_H  = 4'hA,
    RTC_DL = 4'hB,
    RTC_DH = 4'hC
  } rtc_sel_e;

  function automatic logic is_rtc_sel(input logic [3:0] sel);
    return (sel >= 4'h8) && (sel <= 4'hC);
  endfunction

endpackage

// File: rtl/mbc3_rtc.sv
// MBC3 real-time clock: prescaler, live S/M/H/D counters with HALT and sticky
// CARRY, a latched snapshot for reads, and CPU write ports into the live fields.
module mbc3_rtc
  import mbc3_pkg::*;
#(
  parameter int CLK_HZ = 4194304
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_sel,
  input  logic [7:0] wr_data,
  input  logic       latch,
  input  logic [3:0] rd_sel,
  output logic [7:0] rd_data
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0]    presc;
  logic [SEC_W-1:0] s, l_s;
  logic [MIN_W-1:0] m, l_m;
  logic [HR_W-1:0]  h, l_h;
  logic [DAY_W-1:0] d, l_d;
  logic             halt, carry, l_halt, l_carry;

  logic tick, go;
  logic wr_s, wr_m, wr_h, wr_dl, wr_dh;
  logic inc_s, inc_m, inc_h, inc_d;
  logic c_s, c_m, c_h, c_d;

  assign wr_s  = wr_en && (wr_sel == RTC_S);
  assign wr_m  = wr_en && (wr_sel == RTC_M);
  assign wr_h  = wr_en && (wr_sel == RTC_H);
  assign wr_dl = wr_en && (wr_sel == RTC_DL);
  assign wr_dh = wr_en && (wr_sel == RTC_DH);

  assign tick = !rst && (presc == PRESC_MAX);
  assign go   = tick && !halt;

  // A CPU write to a field suppresses its increment, which also kills its carry-out.
  assign inc_s = go && !wr_s;
  assign c_s   = inc_s && (s == SEC_W'(59));
  assign inc_m = c_s && !wr_m;
  assign c_m   = inc_m && (m == MIN_W'(59));
  assign inc_h = c_m && !wr_h;
  assign c_h   = inc_h && (h == HR_W'(23));
  assign inc_d = c_h && !(wr_dl || wr_dh);
  assign c_d   = inc_d && (&d);

  always_ff @(posedge clk) begin
    if (rst || wr_s || tick) presc <= '0;
    else                     presc <= presc + 1'b1;
  end

  // NOTE: the time-of-day counters deliberately have no reset; a bus reset must
  // not lose the time. They start from the all-zero configuration state.
  // Out-of-range values (S/M 60-63, H 24-31) reach 0 by natural overflow, no carry.
  always_ff @(posedge clk) begin
    if (wr_s)       s <= wr_data[SEC_W-1:0];
    else if (inc_s) s <= (s == SEC_W'(59)) ? '0 : s + 1'b1;

    if (wr_m)       m <= wr_data[MIN_W-1:0];
    else if (inc_m) m <= (m == MIN_W'(59)) ? '0 : m + 1'b1;

    if (wr_h)       h <= wr_data[HR_W-1:0];
    else if (inc_h) h <= (h == HR_W'(23)) ? '0 : h + 1'b1;

    if (inc_d) begin
      d <= d + 1'b1;
    end else begin
      if (wr_dl) d[7:0] <= wr_data;
      if (wr_dh) d[8]   <= wr_data[0];
    end

    if (wr_dh) begin
      halt  <= wr_data[6];
      carry <= wr_data[7];
    end else if (c_d) begin
      carry <= 1'b1;
    end

    if (latch) begin
      l_s     <= s;
      l_m     <= m;
      l_h     <= h;
      l_d     <= d;
      l_halt  <= halt;
      l_carry <= carry;
    end
  end

  // NOTE: every path assigns rd_data via the leading default, so no latch is inferred.
  always_comb begin
    rd_data = 8'h00;
    case (rd_sel)
      RTC_S:   rd_data = {2'b00, l_s};
      RTC_M:   rd_data = {2'b00, l_m};
      RTC_H:   rd_data = {3'b000, l_h};
      RTC_DL:  rd_data = l_d[7:0];
      RTC_DH:  rd_data = {l_carry, l_halt, 5'b00000, l_d[8]};
      default: rd_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/mbc3.sv
// MBC3 cartridge mapper: ROM banking, external RAM window and optional RTC.
// Define MBC3_RTC_EN to build the real-time clock (mbc3_rtc).
module mbc3
  import mbc3_pkg::*;
#(
  parameter int CLK_HZ = 4194304
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        wr,
  input  logic        rd,
  output logic [20:0] rom_a,
  output logic        rom_rd,
  input  logic [7:0]  rom_d,
  output logic [14:0] ram_a,
  output logic        ram_we,
  input  logic [7:0]  ram_d
);

  logic                  wr_q;
  logic                  wr_go;
  logic [2:0]            region;
  logic [ROM_BANK_W-1:0] rom_bank;
  logic [3:0]            sel;
  logic                  ram_en;
  logic                  ram_sel_ok;
  logic                  rtc_sel_ok;
  logic [7:0]            rtc_rd;

  // Gating with rst keeps a write that straddles reset from taking effect.
  assign wr_go      = wr && !wr_q && !rst;
  assign region     = a[15:13];
  assign ram_sel_ok = ram_en && (sel[3:2] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b0;
      rom_bank <= ROM_BANK_W'(1);
      sel      <= 4'h0;
      ram_en   <= 1'b0;
    end else begin
      wr_q <= wr;
      if (wr_go) begin
        case (region)
          RGN_RAM_EN:   ram_en   <= (din[3:0] == 4'hA);
          RGN_ROM_BANK: rom_bank <= (din[6:0] == 7'd0) ? ROM_BANK_W'(1) : din[6:0];
          RGN_SEL:      sel      <= din[3:0];
          default:      ;
        endcase
      end
    end
  end

`ifdef MBC3_RTC_EN
  logic latch_armed;
  logic latch_fire;
  logic rtc_wr;

  assign rtc_sel_ok = ram_en && is_rtc_sel(sel);
  assign rtc_wr     = wr_go && (region == RGN_EXT_RAM) && rtc_sel_ok;
  assign latch_fire = wr_go && (region == RGN_LATCH) && (din == 8'h01) && latch_armed;

  always_ff @(posedge clk) begin
    if (rst)                                  latch_armed <= 1'b0;
    else if (wr_go && (region == RGN_LATCH))  latch_armed <= (din == 8'h00);
  end

  mbc3_rtc #(.CLK_HZ(CLK_HZ)) u_rtc (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rtc_wr),
    .wr_sel  (sel),
    .wr_data (din),
    .latch   (latch_fire),
    .rd_sel  (sel),
    .rd_data (rtc_rd)
  );
`else
  localparam int unused_clk_hz = CLK_HZ;
  logic unused_din;

  assign unused_din = din[7];
  assign rtc_sel_ok = 1'b0;
  assign rtc_rd     = 8'hFF;
`endif

  assign rom_a  = a[14] ? {rom_bank, a[13:0]} : {7'd0, a[13:0]};
  assign rom_rd = rd && !a[15];
  assign ram_a  = {sel[1:0], a[12:0]};
  assign ram_we = wr_go && (region == RGN_EXT_RAM) && ram_sel_ok;

  always_comb begin
    dout = 8'hFF;
    if (!a[15]) begin
      dout = rom_d;
    end else if (region == RGN_EXT_RAM) begin
      if (ram_sel_ok)      dout = ram_d;
      else if (rtc_sel_ok) dout = rtc_rd;
    end
  end

endmodule

// File: tb/tb_mbc3.sv
// Scoreboard bench for mbc3: expectations are queued as stimulus is driven and
// compared when outputs are sampled. RTC checks build only with MBC3_RTC_EN.
module tb_mbc3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        wr;
  logic        rd;
  logic [20:0] rom_a;
  logic        rom_rd;
  logic [7:0]  rom_d;
  logic [14:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_d;

  mbc3 #(.CLK_HZ(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .din    (din),
    .dout   (dout),
    .wr     (wr),
    .rd     (rd),
    .rom_a  (rom_a),
    .rom_rd (rom_rd),
    .rom_d  (rom_d),
    .ram_a  (ram_a),
    .ram_we (ram_we),
    .ram_d  (ram_d)
  );

  always #5 clk = ~clk;

  typedef enum int {OBS_DOUT, OBS_ROM_A, OBS_ROM_RD, OBS_RAM_A, OBS_WE_CNT, OBS_WE_ADDR} obs_e;
  typedef struct {
    string       tag;
    obs_e        what;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          wr_edge = 0;
  int          we_count = 0;
  logic [14:0] we_addr = '0;
  int          base;
  int          e;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM write-strobe monitor, sampled between edges.
  always begin
    @(negedge clk);
    #2;
    if (ram_we === 1'b1) begin
      we_count = we_count + 1;
      we_addr  = ram_a;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input obs_e what, input logic [31:0] exp);
    exp_t x;
    x.tag  = tag;
    x.what = what;
    x.exp  = exp;
    sb.push_back(x);
  endtask

  function automatic logic [31:0] observe(input obs_e w);
    case (w)
      OBS_DOUT:    return {24'd0, dout};
      OBS_ROM_A:   return {11'd0, rom_a};
      OBS_ROM_RD:  return {31'd0, rom_rd};
      OBS_RAM_A:   return {17'd0, ram_a};
      OBS_WE_CNT:  return we_count;
      default:     return {17'd0, we_addr};
    endcase
  endfunction

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check(x.tag, observe(x.what), x.exp);
    end
  endtask

  task automatic bus_read(input logic [15:0] addr);
    @(negedge clk);
    a  = addr;
    rd = 1'b1;
    #2;
    drain();
    rd = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input int hold = 1);
    @(negedge clk);
    a   = addr;
    din = data;
    rd  = 1'b0;
    wr  = 1'b1;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    wr      = 1'b0;
    wr_edge = cyc;
  endtask

  // Issue a one-clock write whose rising edge is sampled on posedge number edge_n.
  task automatic write_at(input int edge_n, input logic [15:0] addr, input logic [7:0] data);
    while (cyc < edge_n - 1) @(negedge clk);
    if (cyc != edge_n - 1) check("sched", cyc, edge_n - 1);
    a   = addr;
    din = data;
    wr  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr      = 1'b0;
    wr_edge = cyc;
  endtask

  task automatic rtc_set(input logic [3:0] s, input logic [7:0] v);
    bus_write(16'h4000, {4'h0, s});
    bus_write(16'hA000, v);
  endtask

  task automatic rtc_read(input string tag, input logic [3:0] s, input logic [7:0] v);
    bus_write(16'h4000, {4'h0, s});
    push(tag, OBS_DOUT, v);
    bus_read(16'hA000);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; a = '0; din = '0;
    rom_d = 8'h5C; ram_d = 8'hC3;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state
    push("rst_bank_rom_a", OBS_ROM_A, 32'h04000);
    push("rst_rom_dout",   OBS_DOUT,  32'h5C);
    push("rst_rom_rd",     OBS_ROM_RD, 32'd1);
    bus_read(16'h4000);
    push("rst_ram_off", OBS_DOUT,   32'hFF);
    push("ram_rom_rd0", OBS_ROM_RD, 32'd0);
    push("rst_no_we",   OBS_WE_CNT, 32'd0);
    bus_read(16'hA000);
    push("bank0_rom_a", OBS_ROM_A, 32'h01234);
    bus_read(16'h1234);

    // ROM banking
    bus_write(16'h2100, 8'h00);
    push("bank_zero_as_one", OBS_ROM_A, 32'h04000);
    bus_read(16'h4000);
    bus_write(16'h2000, 8'h7F);
    push("bank_7f_top", OBS_ROM_A, 32'h1FFFFF);
    bus_read(16'h7FFF);
    bus_write(16'h3FFF, 8'h95, 3);
    push("bank_mask_held", OBS_ROM_A, 32'h54321);
    bus_read(16'h4321);
    push("bank0_fixed", OBS_ROM_A, 32'h03FFF);
    bus_read(16'h3FFF);

    // External RAM
    bus_write(16'h0000, 8'h0A);
    bus_write(16'h4000, 8'h02);
    base = we_count;
    bus_write(16'hA123, 8'h5A, 3);
    push("we_once",   OBS_WE_CNT,  base + 1);
    push("we_addr",   OBS_WE_ADDR, 32'h4123);
    push("ram_a",     OBS_RAM_A,   32'h4123);
    push("ram_dout",  OBS_DOUT,    32'hC3);
    bus_read(16'hA123);
    bus_write(16'h0000, 8'h00);
    push("ram_dis_ff", OBS_DOUT, 32'hFF);
    bus_read(16'hA123);
    base = we_count;
    bus_write(16'hA123, 8'h11);
    push("ram_dis_no_we", OBS_WE_CNT, base);
    bus_read(16'h0000);

    // Unmapped selects and addresses
    bus_write(16'h1FFF, 8'h3A);
    bus_write(16'h5FFF, 8'h05);
    push("sel5_ff", OBS_DOUT, 32'hFF);
    bus_read(16'hA000);
    base = we_count;
    bus_write(16'hA000, 8'h11);
    push("sel5_no_we", OBS_WE_CNT, base);
    bus_read(16'hC000);
    bus_write(16'h4000, 8'h0D);
    push("selD_ff", OBS_DOUT, 32'hFF);
    bus_read(16'hBFFF);
    push("addr_c000_ff", OBS_DOUT, 32'hFF);
    bus_read(16'hC000);
    push("addr_8000_ff", OBS_DOUT, 32'hFF);
    bus_read(16'h8000);

`ifndef MBC3_RTC_EN
    bus_write(16'h4000, 8'h08);
    push("no_rtc_sel8_ff", OBS_DOUT, 32'hFF);
    bus_read(16'hA000);
    base = we_count;
    bus_write(16'hA000, 8'h55);
    bus_write(16'h6000, 8'h00);
    bus_write(16'h6000, 8'h01);
    push("no_rtc_no_we", OBS_WE_CNT, base);
    push("no_rtc_still_ff", OBS_DOUT, 32'hFF);
    bus_read(16'hA000);
`endif

    // Reset asserted mid-write suppresses it
    bus_write(16'h2000, 8'h05);
    @(negedge clk);
    rst = 1'b1; a = 16'h2000; din = 8'h09; wr = 1'b1;
    repeat (2) @(negedge clk);
    wr = 1'b0;
    @(negedge clk) rst = 1'b0;
    push("rst_mid_write", OBS_ROM_A, 32'h04000);
    bus_read(16'h4000);
    push("rst_ram_en_off", OBS_DOUT, 32'hFF);
    bus_read(16'hA000);
    bus_write(16'h2000, 8'h03);
    push("post_rst_write", OBS_ROM_A, 32'h0C000);
    bus_read(16'h4000);

`ifdef MBC3_RTC_EN
    bus_write(16'h0000, 8'h0A);

    // Full rollover: 23:59:59 day 511 -> 0 with CARRY
    bus_write(16'h6000, 8'h00);
    rtc_set(4'h8, 8'h00);
    rtc_set(4'hC, 8'h01);
    rtc_set(4'hB, 8'hFF);
    rtc_set(4'hA, 8'd23);
    rtc_set(4'h9, 8'd59);
    rtc_set(4'h8, 8'd59);
    e = wr_edge;
    write_at(e + 5, 16'h6000, 8'h01);
    rtc_read("roll_s",  4'h8, 8'h00);
    rtc_read("roll_m",  4'h9, 8'h00);
    rtc_read("roll_h",  4'hA, 8'h00);
    rtc_read("roll_dl", 4'hB, 8'h00);
    rtc_read("roll_dh", 4'hC, 8'h80);

    // Write to M on the same clk as the S->M carry: write wins
    bus_write(16'h6000, 8'h00);
    bus_write(16'h4000, 8'h08);
    bus_write(16'hA000, 8'd59);
    e = wr_edge;
    write_at(e + 2, 16'h4000, 8'h09);
    write_at(e + 4, 16'hA000, 8'h0A);
    write_at(e + 6, 16'h6000, 8'h01);
    rtc_read("coll_s", 4'h8, 8'h00);
    rtc_read("coll_m", 4'h9, 8'h0A);
    rtc_read("coll_h", 4'hA, 8'h00);

    // Out-of-range seconds
    bus_write(16'h6000, 8'h00);
    rtc_set(4'h8, 8'd62);
    e = wr_edge;
    write_at(e + 5, 16'h6000, 8'h01);
    rtc_read("oor_s63", 4'h8, 8'd63);
    bus_write(16'h6000, 8'h00);
    rtc_set(4'h8, 8'd62);
    e = wr_edge;
    write_at(e + 9, 16'h6000, 8'h01);
    rtc_read("oor_s0",  4'h8, 8'd0);
    rtc_read("oor_m_nc", 4'h9, 8'h0A);

    // HALT freezes the count
    rtc_set(4'hC, 8'h40);
    bus_write(16'h6000, 8'h00);
    rtc_set(4'h8, 8'h11);
    repeat (40) @(posedge clk);
    bus_write(16'h6000, 8'h01);
    rtc_read("halt_s",  4'h8, 8'h11);
    rtc_read("halt_dh", 4'hC, 8'h40);

    // Latch sequences
    rtc_set(4'h8, 8'h21);
    bus_write(16'h6000, 8'h01);
    bus_write(16'h6000, 8'h01);
    rtc_read("latch_01_01", 4'h8, 8'h11);
    bus_write(16'h6000, 8'h00);
    bus_write(16'h6000, 8'h02);
    bus_write(16'h6000, 8'h01);
    rtc_read("latch_00_02_01", 4'h8, 8'h11);
    bus_write(16'h6000, 8'h00);
    bus_write(16'h6000, 8'h01);
    rtc_read("latch_00_01", 4'h8, 8'h21);

    // RTC select with RAM disabled
    bus_write(16'h0000, 8'h00);
    rtc_read("rtc_ram_off_ff", 4'h8, 8'hFF);
`endif

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mbc3.md
MBC3 -- requirements
Module: mbc3

Interface
REQ-001 Parameter CLK_HZ, default 4194304, clk cycles per RTC second.
REQ-002 clk  in  1  system clock, same 4.19 MHz domain as the bus master.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 a  in  16  cartridge address bus.
REQ-005 din  in  8  write data from bus master.
REQ-006 dout  out  8  read data to bus master.
REQ-007 wr  in  1  write enable, level, may stay high several clks.
REQ-008 rd  in  1  read enable, level.
REQ-009 rom_a  out  21  ROM byte address (2 MB).
REQ-010 rom_rd  out  1  ROM read strobe.
REQ-011 rom_d  in  8  ROM data.
REQ-012 ram_a  out  15  SRAM byte address (32 KB).
REQ-013 ram_we  out  1  SRAM write strobe, one clk.
REQ-014 ram_d  in  8  SRAM read data; SRAM write data is din.

Function
REQ-015 Register writes SHALL occur only on the wr rising edge (wr & ~wr_q), once per bus write regardless of wr width.
REQ-016 Write 0000-1FFF: ram_en SHALL become 1 iff din[3:0]==4'hA, else 0.
REQ-017 Write 2000-3FFF: rom_bank SHALL take din[6:0], with 0 stored as 1.
REQ-018 Write 4000-5FFF: sel SHALL take din[3:0].
REQ-019 Write 6000-7FFF: latch SHALL fire when din==01 and the previous write to this range was 00; any other sequence does not fire.
REQ-020 Read 0000-3FFF: rom_a SHALL be {7'd0,a[13:0]}; 4000-7FFF: {rom_bank,a[13:0]}; rom_rd = rd & ~a[15]; dout = rom_d.
REQ-021 A000-BFFF, ram_en=1, sel 0-3: ram_a = {sel[1:0],a[12:0]}, dout = ram_d, ram_we pulses on the wr rising edge.
REQ-022 A000-BFFF with ram_en=0, or sel in 4-7 or D-F: dout SHALL be 8'hFF and writes are ignored.
REQ-023 Any other address: dout SHALL be 8'hFF. dout is combinational from a with zero added latency.
REQ-024 RTC live counters: S 6b, M 6b, H 5b, D 9b, HALT, CARRY. The prescaler ticks once per CLK_HZ clks.
REQ-025 Tick, HALT=0: S+1. S 59->0 carries to M. M 59->0 carries to H. H 23->0 carries to D. D 511->0 sets CARRY, which is sticky.
REQ-026 Out-of-range S/M (60-63) or H (24-31) SHALL count up to the field maximum, then wrap to 0 without carry.
REQ-027 Latch SHALL copy all live counters into latched registers in one clk. Reads at sel 08-0C return latched S, M, H, D[7:0], and {CARRY,HALT,5'b0,D[8]}. Unused bits read 0.
REQ-028 RTC writes at sel 08-0C (ram_en=1) SHALL update the live field. A write to S also clears the prescaler. A write to D-high sets D[8], HALT, and CARRY from din[0], din[6], and din[7].
REQ-029 When a tick and a CPU write to the same field coincide, the write wins and the tick carry into that field is dropped.

Reset
REQ-030 rst SHALL set rom_bank=1, sel=0, ram_en=0, latch state cleared, wr_q=0, and ram_we=0.
REQ-031 rst SHALL clear the prescaler. RTC counters SHALL NOT be reset; they are initialised to 0 only at configuration.
REQ-032 A rst asserted mid-write SHALL suppress the write; the next wr rising edge after rst deasserts is honoured.

Configuration
REQ-033 Macro MBC3_RTC_EN. When defined, REQ-024 to REQ-029 apply.
REQ-034 When MBC3_RTC_EN is undefined, no RTC logic is built, sel 08-0C behaves as REQ-022, and the latch writes are ignored.

Structure
REQ-035 Package mbc3_pkg SHALL hold the address-range constants, the RTC select codes 08-0C, and the field widths.
REQ-036 Sub-module mbc3_rtc SHALL contain the prescaler, live and latched counters, and write ports. It is instantiated only under MBC3_RTC_EN.

Verification
REQ-037 Write 00 to 2100, read 4000 -> rom_a=0x04000. Write 7F, read 7FFF -> rom_a=0x1FFFFF.
REQ-038 Write 0A to 0000, sel=2, write 5A to A123 held 3 clks -> exactly one ram_we, ram_a=0x4123. Write 00 to 0000, read A123 -> FF.
REQ-039 CLK_HZ=4, RTC enabled: set H=23, M=59, S=59, D=511. After 4 clks, latch (00 then 01) -> reads S=0, M=0, H=0, D=0, DH=0x80.
REQ-040 Set S=62 -> 1 tick S=63, 2 ticks S=0 with M unchanged. Set HALT=1 -> S frozen over 10 ticks.
REQ-041 Latch sequences 01/01 and 00/02/01 -> latched values unchanged. Sequence 00/01 -> latched values update.
REQ-042 Build without MBC3_RTC_EN, ram_en=1, sel=08, read A000 -> FF; write ignored.
